// File: rtl/free_list.sv
// Circular free list of physical registers for rename: zero-latency allocation, all-or-nothing
// (alloc_ready_o low stalls every lane), pushes land next cycle, one-cycle rollback to the arch head.
module free_list #(
   parameter int  PHY_REG_NUM  = 64,
   parameter int  DECODE_WIDTH = 2,
   localparam int PW           = $clog2(PHY_REG_NUM)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DECODE_WIDTH-1:0]        alloc_valid_i,
   output logic                           alloc_ready_o,
   output logic [DECODE_WIDTH-1:0][PW-1:0] preg_o,
   input  logic [DECODE_WIDTH-1:0]        free_i,
   input  logic [DECODE_WIDTH-1:0][PW-1:0] old_preg_i,
   input  logic                           restore_i,
   output logic [PW:0]                    free_count_o,
   output logic                           overflow_o
);

   typedef logic [PW:0] ptr_t;

   localparam ptr_t FULL = ptr_t'(PHY_REG_NUM);

   logic [PW-1:0] queue [PHY_REG_NUM];

   ptr_t spec_head;
   ptr_t arch_head;
   ptr_t tail;
   ptr_t count;

   ptr_t n_req;
   ptr_t rd_ptr;
   logic alloc_fire;

   ptr_t                           n_push;
   ptr_t                           n_free;
   ptr_t                           wr_ptr;
   ptr_t                           arch_head_next;
   logic [DECODE_WIDTH-1:0]        wr_en;
   logic [DECODE_WIDTH-1:0][PW-1:0] wr_idx;
   logic                           drop;

   // Wrap bit makes the subtraction distinguish full (64) from empty (0).
   assign count        = tail - spec_head;
   assign free_count_o = count;

   // Requesting lanes are compacted onto consecutive entries from spec_head.
   always_comb begin
      n_req  = '0;
      rd_ptr = '0;
      preg_o = '0;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         if (alloc_valid_i[i]) begin
            rd_ptr    = spec_head + n_req;
            preg_o[i] = queue[rd_ptr[PW-1:0]];
            n_req     = n_req + ptr_t'(1);
         end
      end
   end

   assign alloc_ready_o = (count >= n_req) && !restore_i;
   assign alloc_fire    = alloc_ready_o && (n_req != '0);

   // Each push is judged against the occupancy including lower lanes' pushes this cycle.
   always_comb begin
      n_push = '0;
      n_free = '0;
      wr_ptr = '0;
      wr_en  = '0;
      wr_idx = '0;
      drop   = 1'b0;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         if (free_i[i]) begin
            n_free = n_free + ptr_t'(1);
            if ((count + n_push) < FULL) begin
               wr_ptr    = tail + n_push;
               wr_en[i]  = 1'b1;
               wr_idx[i] = wr_ptr[PW-1:0];
               n_push    = n_push + ptr_t'(1);
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   // Every committed dest retires exactly one allocation, even if its push was dropped.
   assign arch_head_next = arch_head + n_free;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < PHY_REG_NUM; k++) begin
            queue[k] <= PW'(k + 1);
         end
         spec_head  <= '0;
         arch_head  <= '0;
         tail       <= ptr_t'(PHY_REG_NUM - 1);
         overflow_o <= 1'b0;
      end else begin
         for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (wr_en[i]) begin
               queue[wr_idx[i]] <= old_preg_i[i];
            end
         end
         tail      <= tail + n_push;
         arch_head <= arch_head_next;
         if (restore_i) begin
            spec_head <= arch_head_next;
         end else if (alloc_fire) begin
            spec_head <= spec_head + n_req;
         end
         if (drop) begin
            overflow_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: allocation, drain, wrap, restore and overflow scenarios.
module tb_free_list;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       alloc_valid;
   logic             alloc_ready;
   logic [1:0][5:0]  preg;
   logic [1:0]       free_v;
   logic [1:0][5:0]  old_preg;
   logic             restore;
   logic [6:0]       free_count;
   logic             overflow;

   int n_cmp = 0;
   int n_err = 0;

   free_list #(.PHY_REG_NUM(64), .DECODE_WIDTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .alloc_valid_i (alloc_valid),
      .alloc_ready_o (alloc_ready),
      .preg_o        (preg),
      .free_i        (free_v),
      .old_preg_i    (old_preg),
      .restore_i     (restore),
      .free_count_o  (free_count),
      .overflow_o    (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid = 2'b00;
      free_v      = 2'b00;
      old_preg    = '0;
      restore     = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;

      // 1: two double allocations after reset
      do_reset();
      chk("rst_count", free_count, 63);
      chk("rst_ready", alloc_ready, 1);
      chk("rst_ovf", overflow, 0);
      alloc_valid = 2'b11;
      #1;
      chk("a1_p0", preg[0], 1);
      chk("a1_p1", preg[1], 2);
      cyc();
      chk("a1_count", free_count, 61);
      chk("a2_p0", preg[0], 3);
      chk("a2_p1", preg[1], 4);
      cyc();
      alloc_valid = 2'b00;
      #1;
      chk("a2_count", free_count, 59);

      // 2: single request on upper lane gets compacted
      do_reset();
      alloc_valid = 2'b10;
      #1;
      chk("c_p1", preg[1], 1);
      chk("c_p0", preg[0], 0);
      chk("c_ready", alloc_ready, 1);
      cyc();
      alloc_valid = 2'b00;
      #1;
      chk("c_count", free_count, 62);

      // 3: drain to one, stall, then take the last entry
      do_reset();
      alloc_valid = 2'b11;
      repeat (31) cyc();
      chk("d_count1", free_count, 1);
      chk("d_stall_rdy", alloc_ready, 0);
      cyc();
      chk("d_unchanged", free_count, 1);
      alloc_valid = 2'b01;
      #1;
      chk("d_last_p0", preg[0], 63);
      chk("d_last_rdy", alloc_ready, 1);
      cyc();
      alloc_valid = 2'b00;
      #1;
      chk("d_empty", free_count, 0);
      alloc_valid = 2'b01;
      #1;
      chk("d_empty_rdy1", alloc_ready, 0);
      alloc_valid = 2'b10;
      #1;
      chk("d_empty_rdy2", alloc_ready, 0);

      // 4: frees written across the 63/0 boundary come back in lane order
      alloc_valid = 2'b00;
      free_v      = 2'b11;
      old_preg[1] = 6'd7;
      old_preg[0] = 6'd5;
      cyc();
      free_v      = 2'b00;
      alloc_valid = 2'b11;
      #1;
      chk("w_count", free_count, 2);
      chk("w_ready", alloc_ready, 1);
      chk("w_p0", preg[0], 5);
      chk("w_p1", preg[1], 7);
      cyc();
      alloc_valid = 2'b00;
      #1;
      chk("w_empty", free_count, 0);
      chk("w_ovf", overflow, 0);

      // 5: restore with same-cycle commits
      do_reset();
      alloc_valid = 2'b11;
      cyc();
      cyc();
      free_v      = 2'b11;
      old_preg[1] = 6'd11;
      old_preg[0] = 6'd10;
      restore     = 1'b1;
      #1;
      chk("r_ready", alloc_ready, 0);
      cyc();
      free_v  = 2'b00;
      restore = 1'b0;
      #1;
      chk("r_count", free_count, 63);
      chk("r_p0", preg[0], 3);
      chk("r_p1", preg[1], 4);
      cyc();
      alloc_valid = 2'b00;
      #1;
      chk("r_count2", free_count, 61);

      // 6: overflow on the second lane, sticky until reset
      do_reset();
      free_v      = 2'b11;
      old_preg[1] = 6'd9;
      old_preg[0] = 6'd8;
      cyc();
      free_v = 2'b00;
      #1;
      chk("o_flag", overflow, 1);
      chk("o_count", free_count, 64);
      cyc();
      chk("o_sticky", overflow, 1);
      do_reset();
      chk("o_cleared", overflow, 0);
      chk("o_rst_count", free_count, 63);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
